// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
// Contents: controller state encoding, next-PC select codes, branch-code
// ranges, scoreboard entry layout and branch-code classification helpers.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } ctrl_state_t;

   localparam logic [1:0] PC_SEL_SEQ = 2'd0;
   localparam logic [1:0] PC_SEL_JMP = 2'd1;
   localparam logic [1:0] PC_SEL_BR  = 2'd2;

   localparam logic [3:0] BR_A_LO = 4'd1;
   localparam logic [3:0] BR_A_HI = 4'd6;
   localparam logic [3:0] BR_B_LO = 4'd7;
   localparam logic [3:0] BR_B_HI = 4'd12;

   // One in-flight instruction: valid, writes A, writes B, is a load, is a branch.
   typedef struct packed {
      logic v;
      logic wa;
      logic wb;
      logic ld;
      logic brx;
   } sb_entry_t;

   function automatic logic br_tests_a(input logic [3:0] code);
      return (code >= BR_A_LO) && (code <= BR_A_HI);
   endfunction

   function automatic logic br_tests_b(input logic [3:0] code);
      return (code >= BR_B_LO) && (code <= BR_B_HI);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// rtl/pipeline_hazard_ctrl_scoreboard.sv - EX/MEM writer scoreboard and RAW match logic
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   issue             ID instruction enters EX this edge
//   id_entry          fields of the ID instruction
//   reads_a, reads_b  ID instruction reads register A / B
//   hazard            ID read collides with an in-flight writer
//   ex_brx            EX entry is a branch
module hazard_scoreboard
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int FORWARDING = 1
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      issue,
   input  sb_entry_t id_entry,
   input  logic      reads_a,
   input  logic      reads_b,
   output logic      hazard,
   output logic      ex_brx
);

   sb_entry_t ex_q;
   logic      mem_v;
   logic      mem_wa;
   logic      mem_wb;
   logic      ex_match;
   logic      mem_match;

   // MEM only needs to remember which registers are still pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q   <= '0;
         mem_v  <= 1'b0;
         mem_wa <= 1'b0;
         mem_wb <= 1'b0;
      end else begin
         mem_v  <= ex_q.v;
         mem_wa <= ex_q.wa;
         mem_wb <= ex_q.wb;
         ex_q   <= issue ? id_entry : '0;
      end
   end

   assign ex_match  = ex_q.v & ((ex_q.wa & reads_a) | (ex_q.wb & reads_b));
   assign mem_match = mem_v & ((mem_wa & reads_a) | (mem_wb & reads_b));

   // With forwarding only a load in EX is too late; without it the writer
   // must have reached WB, which writes through to the register read.
   assign hazard = (FORWARDING != 0) ? (ex_match & ex_q.ld) : (ex_match | mem_match);
   assign ex_brx = ex_q.v & ex_q.brx;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/next-PC sequencing for the 5-stage accumulator pipeline
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   id_valid                            ID holds a valid instruction
//   id_write_to_a, id_write_to_b        decoder register write enables
//   id_mux_pre_alu_a, id_mux_pre_alu_b  decoder operand selects (0 = register)
//   id_write_back_mux                   1 = load
//   id_jump, id_branch_taken            decoder jump and branch code
//   ex_branch_cond                      branch in EX evaluated true
//   pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pc_sel  pipeline controls
//   ctrl_state                          0 RUN, 1 STALL, 2 FLUSH
//   stall_cnt, flush_cnt                saturating event counters
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int FORWARDING = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic             id_write_to_a,
   input  logic             id_write_to_b,
   input  logic             id_mux_pre_alu_a,
   input  logic             id_mux_pre_alu_b,
   input  logic             id_write_back_mux,
   input  logic             id_jump,
   input  logic [3:0]       id_branch_taken,
   input  logic             ex_branch_cond,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic [1:0]       pc_sel,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ctrl_state_t state;
   ctrl_state_t state_nxt;
   sb_entry_t   id_entry;
   logic        id_live;
   logic        no_branch;
   logic        reads_a;
   logic        reads_b;
   logic        hazard;
   logic        ex_brx;
   logic        kill;
   logic        jump;
   logic        issue;

   // The slot behind a jump or taken branch is dead; reset also silences ID
   // so every control output is low while reset is held.
   assign id_live   = id_valid & (state != ST_FLUSH) & ~reset;
   assign no_branch = (id_branch_taken == 4'd0);
   assign reads_a   = id_live & ((~id_mux_pre_alu_a & ~id_jump & no_branch) | br_tests_a(id_branch_taken));
   assign reads_b   = id_live & ((~id_mux_pre_alu_b & ~id_jump & no_branch) | br_tests_b(id_branch_taken));

   assign kill  = ex_brx & ex_branch_cond;
   assign jump  = id_live & id_jump;
   assign issue = id_live & ~hazard & ~kill;

   assign id_entry = '{v:   1'b1,
                       wa:  id_write_to_a,
                       wb:  id_write_to_b,
                       ld:  id_write_back_mux,
                       brx: br_tests_a(id_branch_taken) | br_tests_b(id_branch_taken)};

   hazard_scoreboard #(
      .FORWARDING (FORWARDING)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .issue    (issue),
      .id_entry (id_entry),
      .reads_a  (reads_a),
      .reads_b  (reads_b),
      .hazard   (hazard),
      .ex_brx   (ex_brx)
   );

   // Priority: taken branch kills the stalled instruction, so no stall is raised.
   always_comb begin
      state_nxt    = ST_RUN;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      pc_sel       = PC_SEL_SEQ;
      if (kill) begin
         pc_sel       = PC_SEL_BR;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         state_nxt    = ST_FLUSH;
      end else if (hazard) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_bubble = 1'b1;
         state_nxt    = ST_STALL;
      end else if (jump) begin
         pc_sel      = PC_SEL_JMP;
         if_id_flush = 1'b1;
         state_nxt   = ST_FLUSH;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (if_id_flush && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       id_valid, id_write_to_a, id_write_to_b;
   logic       id_mux_pre_alu_a, id_mux_pre_alu_b, id_write_back_mux;
   logic       id_jump, ex_branch_cond;
   logic [3:0] id_branch_taken;

   // _f: forwarding, 16-bit counters; _n: no forwarding, 4-bit counters
   logic        pc_stall_f, if_id_stall_f, id_ex_bubble_f, if_id_flush_f;
   logic [1:0]  pc_sel_f, ctrl_state_f;
   logic [15:0] stall_cnt_f, flush_cnt_f;
   logic        pc_stall_n, if_id_stall_n, id_ex_bubble_n, if_id_flush_n;
   logic [1:0]  pc_sel_n, ctrl_state_n;
   logic [3:0]  stall_cnt_n, flush_cnt_n;

   pipeline_hazard_ctrl #(.FORWARDING(1), .CNT_W(16)) dut_f (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_write_to_a(id_write_to_a), .id_write_to_b(id_write_to_b),
      .id_mux_pre_alu_a(id_mux_pre_alu_a), .id_mux_pre_alu_b(id_mux_pre_alu_b),
      .id_write_back_mux(id_write_back_mux), .id_jump(id_jump),
      .id_branch_taken(id_branch_taken), .ex_branch_cond(ex_branch_cond),
      .pc_stall(pc_stall_f), .if_id_stall(if_id_stall_f), .id_ex_bubble(id_ex_bubble_f),
      .if_id_flush(if_id_flush_f), .pc_sel(pc_sel_f), .ctrl_state(ctrl_state_f),
      .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f));

   pipeline_hazard_ctrl #(.FORWARDING(0), .CNT_W(4)) dut_n (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_write_to_a(id_write_to_a), .id_write_to_b(id_write_to_b),
      .id_mux_pre_alu_a(id_mux_pre_alu_a), .id_mux_pre_alu_b(id_mux_pre_alu_b),
      .id_write_back_mux(id_write_back_mux), .id_jump(id_jump),
      .id_branch_taken(id_branch_taken), .ex_branch_cond(ex_branch_cond),
      .pc_stall(pc_stall_n), .if_id_stall(if_id_stall_n), .id_ex_bubble(id_ex_bubble_n),
      .if_id_flush(if_id_flush_n), .pc_sel(pc_sel_n), .ctrl_state(ctrl_state_n),
      .stall_cnt(stall_cnt_n), .flush_cnt(flush_cnt_n));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a record of every instruction still ahead of ID,
   // indexed by age in cycles since issue (0 = issued last cycle).
   typedef struct packed { bit v; bit wa; bit wb; bit ld; bit br; } rec_t;
   typedef struct packed { int stall; int bubble; int flush; int sel; int nxt; bit issue; } exp_t;

   rec_t fl [2][2];
   int   m_state [2];
   int   m_stall [2];
   int   m_flush [2];
   int   cnt_max [2] = '{65535, 15};
   bit   fw      [2] = '{1'b1, 1'b0};

   logic       s_stall_f, s_bubble_f, s_flush_f, s_stall_n, s_bubble_n, s_flush_n;
   logic [1:0] s_sel_f, s_state_f, s_sel_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         fl[i][0] = '0; fl[i][1] = '0;
         m_state[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
      end
   endtask

   function automatic exp_t model_eval(input int i);
      exp_t e;
      bit live, ra, rb, kill, hz;
      e    = '0;
      live = !reset && id_valid && (m_state[i] != 2);
      ra   = live && ((id_branch_taken >= 1 && id_branch_taken <= 6) ||
                      (id_branch_taken == 0 && !id_jump && !id_mux_pre_alu_a));
      rb   = live && ((id_branch_taken >= 7 && id_branch_taken <= 12) ||
                      (id_branch_taken == 0 && !id_jump && !id_mux_pre_alu_b));
      kill = !reset && fl[i][0].v && fl[i][0].br && ex_branch_cond;
      hz   = 0;
      for (int k = 0; k < 2; k++) begin
         if (fl[i][k].v && ((fl[i][k].wa && ra) || (fl[i][k].wb && rb)) &&
             (fw[i] ? (k == 0 && fl[i][k].ld) : 1'b1))
            hz = 1;
      end
      if (kill) begin
         e.sel = 2; e.flush = 1; e.bubble = 1; e.nxt = 2;
      end else if (hz) begin
         e.stall = 1; e.bubble = 1; e.nxt = 1;
      end else if (live && id_jump) begin
         e.sel = 1; e.flush = 1; e.nxt = 2;
      end
      e.issue = live && !hz && !kill;
      return e;
   endfunction

   task automatic check_all();
      exp_t ef, en;
      if (reset) m_reset();
      ef = model_eval(0);
      en = model_eval(1);
      chk("f_pc_stall",    32'(pc_stall_f),     ef.stall);
      chk("f_if_id_stall", 32'(if_id_stall_f),  ef.stall);
      chk("f_bubble",      32'(id_ex_bubble_f), ef.bubble);
      chk("f_flush",       32'(if_id_flush_f),  ef.flush);
      chk("f_pc_sel",      32'(pc_sel_f),       ef.sel);
      chk("f_state",       32'(ctrl_state_f),   m_state[0]);
      chk("f_stall_cnt",   32'(stall_cnt_f),    m_stall[0]);
      chk("f_flush_cnt",   32'(flush_cnt_f),    m_flush[0]);
      chk("n_pc_stall",    32'(pc_stall_n),     en.stall);
      chk("n_if_id_stall", 32'(if_id_stall_n),  en.stall);
      chk("n_bubble",      32'(id_ex_bubble_n), en.bubble);
      chk("n_flush",       32'(if_id_flush_n),  en.flush);
      chk("n_pc_sel",      32'(pc_sel_n),       en.sel);
      chk("n_state",       32'(ctrl_state_n),   m_state[1]);
      chk("n_stall_cnt",   32'(stall_cnt_n),    m_stall[1]);
      chk("n_flush_cnt",   32'(flush_cnt_n),    m_flush[1]);
   endtask

   task automatic advance();
      exp_t e [2];
      rec_t r;
      r.v  = 1; r.wa = id_write_to_a; r.wb = id_write_to_b; r.ld = id_write_back_mux;
      r.br = (id_branch_taken >= 1 && id_branch_taken <= 12);
      e[0] = model_eval(0);
      e[1] = model_eval(1);
      if (reset) begin
         m_reset();
      end else begin
         for (int i = 0; i < 2; i++) begin
            fl[i][1]   = fl[i][0];
            fl[i][0]   = e[i].issue ? r : rec_t'(0);
            m_state[i] = e[i].nxt;
            if (e[i].stall != 0 && m_stall[i] < cnt_max[i]) m_stall[i]++;
            if (e[i].flush != 0 && m_flush[i] < cnt_max[i]) m_flush[i]++;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      s_stall_f = pc_stall_f; s_bubble_f = id_ex_bubble_f; s_flush_f = if_id_flush_f;
      s_sel_f   = pc_sel_f;   s_state_f  = ctrl_state_f;
      s_stall_n = pc_stall_n; s_bubble_n = id_ex_bubble_n; s_flush_n = if_id_flush_n;
      s_sel_n   = pc_sel_n;
      advance();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit wa, input bit wb, input bit ma, input bit mb,
                        input bit ld, input bit j, input logic [3:0] br, input bit cond);
      id_valid = v; id_write_to_a = wa; id_write_to_b = wb;
      id_mux_pre_alu_a = ma; id_mux_pre_alu_b = mb; id_write_back_mux = ld;
      id_jump = j; id_branch_taken = br; ex_branch_cond = cond;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 4'd0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      nop();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      m_reset();
      nop();
      #1;
      step();
      chk("rst_state", 32'(ctrl_state_f), 0);
      chk("rst_pc_sel", 32'(pc_sel_f), 0);
      reset = 1'b0;
      step();

      // Load-use with forwarding: exactly one stall, then ADDA issues.
      do_reset();
      drive(1, 1, 0, 1, 1, 1, 0, 4'd0, 0); step();            // LDA
      drive(1, 1, 0, 0, 1, 0, 0, 4'd0, 0); step();            // ADDA
      chk("t1_stall", 32'(s_stall_f), 1);
      chk("t1_bubble", 32'(s_bubble_f), 1);
      step();
      chk("t1_no_stall", 32'(s_stall_f), 0);
      chk("t1_stall_cnt", 32'(stall_cnt_f), 1);

      // No forwarding: adjacent producer costs 2 stalls, one gap costs 1.
      do_reset();
      drive(1, 1, 0, 0, 1, 0, 0, 4'd0, 0); step();            // ADDCA
      step(); step(); step();                                  // SUBA
      chk("t2_adjacent", 32'(stall_cnt_n), 2);
      do_reset();
      drive(1, 1, 0, 0, 1, 0, 0, 4'd0, 0); step();
      nop(); step();
      drive(1, 1, 0, 0, 1, 0, 0, 4'd0, 0); step(); step();
      chk("t2_gap", 32'(stall_cnt_n), 1);

      // Jump: one flush cycle, FLUSH for one cycle, back to RUN.
      do_reset();
      drive(1, 0, 0, 1, 1, 0, 1, 4'd0, 0); step();
      chk("t3_pc_sel", 32'(s_sel_f), 1);
      chk("t3_flush", 32'(s_flush_f), 1);
      nop(); step();
      chk("t3_state_flush", 32'(s_state_f), 2);
      step();
      chk("t3_state_run", 32'(s_state_f), 0);
      chk("t3_flush_cnt", 32'(flush_cnt_f), 1);

      // Taken branch in EX beats a pending hazard on LDB (no forwarding).
      do_reset();
      drive(1, 0, 1, 1, 0, 0, 0, 4'd0, 0); step();            // ADDB
      drive(1, 0, 0, 1, 1, 0, 0, 4'd1, 0); step();            // BAEQ
      drive(1, 0, 1, 1, 0, 1, 0, 4'd0, 1); step();            // LDB, branch taken
      chk("t4_pc_sel", 32'(s_sel_n), 2);
      chk("t4_flush", 32'(s_flush_n), 1);
      chk("t4_bubble", 32'(s_bubble_n), 1);
      chk("t4_no_stall", 32'(s_stall_n), 0);
      chk("t4_stall_cnt", 32'(stall_cnt_n), 0);
      nop(); step();

      // Asynchronous reset in the middle of a stall.
      do_reset();
      drive(1, 1, 0, 1, 1, 1, 0, 4'd0, 0); step();            // LDA
      drive(1, 1, 0, 0, 1, 0, 0, 4'd0, 0);                    // ADDA
      #2;
      chk("t5_pre_stall", 32'(pc_stall_f), 1);
      reset = 1'b1;
      #1;
      chk("t5_stall_low", 32'(pc_stall_f), 0);
      chk("t5_bubble_low", 32'(id_ex_bubble_f), 0);
      chk("t5_cnt_zero", 32'(stall_cnt_f), 0);
      m_reset();
      step();
      reset = 1'b0;
      step();
      chk("t5_no_residual", 32'(s_stall_f), 0);
      drive(1, 1, 0, 1, 1, 1, 0, 4'd0, 0); step();
      drive(1, 1, 0, 0, 1, 0, 0, 4'd0, 0); step(); step();
      chk("t5_replay_cnt", 32'(stall_cnt_f), 1);

      // Saturation of the 4-bit stall counter: far more than 2^4+3 stalls.
      do_reset();
      drive(1, 1, 0, 0, 1, 0, 0, 4'd0, 0);
      for (int c = 0; c < 40; c++) step();
      chk("t6_sat", 32'(stall_cnt_n), 15);

      // Random instruction stream against the model.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 99) < 2);
         drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 12)) : 4'd0,
               1'($urandom));
         step();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
